// File: rtl/prach_pkt_sched_if.sv
// Bundle of the scheduler's request/ack, result-RAM read and Avalon-ST source signals.
// master = scheduler side, slave = environment (buffers, RAM, framer) side.
interface prach_pkt_sched_if #(
  parameter int N_REQ  = 24,
  parameter int LEN_W  = 12,
  parameter int DATA_W = 32
);
  logic [LEN_W-1:0]  ctrl_pkt_len;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ack;
  logic              rd_en;
  logic [4:0]        rd_sel;
  logic [LEN_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] avst_source_data;
  logic              avst_source_valid;
  logic [15:0]       avst_source_channel;
  logic              avst_source_startofpacket;
  logic              avst_source_endofpacket;
  logic              avst_source_ready;

  // Avalon-ST, ready latency 0: a beat transfers on a rising edge where valid && ready;
  // while valid && !ready the source holds data, channel, sop and eop unchanged.
  modport master (
    input  ctrl_pkt_len, req_valid, rd_data, avst_source_ready,
    output req_ack, rd_en, rd_sel, rd_addr, avst_source_data, avst_source_valid,
           avst_source_channel, avst_source_startofpacket, avst_source_endofpacket
  );

  modport slave (
    output ctrl_pkt_len, req_valid, rd_data, avst_source_ready,
    input  req_ack, rd_en, rd_sel, rd_addr, avst_source_data, avst_source_valid,
           avst_source_channel, avst_source_startofpacket, avst_source_endofpacket
  );
endinterface

// File: rtl/prach_pkt_sched.sv
// Round-robin drain of PRACH result buffers onto one Avalon-ST source, with a skid FIFO absorbing RAM latency.
// Optional feature macro PRACH_PKT_HDR_EN: prefix each packet with a {4'h0, len, channel} header beat.
module prach_pkt_sched #(
  parameter int N_REQ  = 24,
  parameter int LEN_W  = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic                         clk_dsp,
  input  logic                         rst_dsp,
  prach_pkt_sched_if.master            bus,
  output logic [1:0]                   o_dbg_state,
  output logic [$clog2(FIFO_D+1)-1:0]  o_dbg_fifo_cnt
);
  localparam int SEL_W = 5;
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = $clog2(FIFO_D+1);
  localparam int WRD_W = DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ACK} state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_rr_ptr, r_grant, w_gnt;
  logic               w_gnt_vld, w_grant_go, w_rd_en, w_last_addr, w_smp_sop;
  logic [LEN_W-1:0]   r_len, r_addr;
  logic [RD_LAT-1:0]  r_pv, r_ps, r_pe;
  int                 w_inflight;
  logic [WRD_W-1:0]   r_mem [FIFO_D];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_push, w_pop, w_empty, w_hdr_push;
  logic [WRD_W-1:0]   w_wr_word, w_head, w_hdr_word;

  // First requester at or after rr_ptr+1 (wrapping); lowest offset wins since it is assigned last.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(r_rr_ptr) + k) % N_REQ;
      if (bus.req_valid[SEL_W'(j)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SEL_W'(j);
      end
    end
  end

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < RD_LAT; i++) w_inflight += int'(r_pv[i]);
  end

  assign w_last_addr = (r_addr == r_len - LEN_W'(1));
  assign w_empty     = (r_cnt == '0);
  assign w_pop       = !w_empty && bus.avst_source_ready;
  assign w_head      = r_mem[r_rd_ptr];

`ifdef PRACH_PKT_HDR_EN
  assign w_hdr_push = w_grant_go;
  assign w_hdr_word = {DATA_W'({4'h0, bus.ctrl_pkt_len, 16'(w_gnt)}), 1'b1, 1'b0};
  assign w_smp_sop  = 1'b0;
`else
  assign w_hdr_push = 1'b0;
  assign w_hdr_word = '0;
  assign w_smp_sop  = (r_addr == '0);
`endif

  // Reads are only issued while every outstanding beat is guaranteed a FIFO slot.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_go  = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld && (bus.ctrl_pkt_len != '0)) begin
          w_grant_go  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((int'(r_cnt) + w_inflight) < FIFO_D) begin
          w_rd_en = 1'b1;
          if (w_last_addr) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (w_pop && w_head[0]) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= SEL_W'(N_REQ - 1);
      r_grant  <= '0;
      r_len    <= '0;
      r_addr   <= '0;
      r_pv     <= '0;
      r_ps     <= '0;
      r_pe     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_go) begin
        r_grant  <= w_gnt;
        r_rr_ptr <= w_gnt;
        r_len    <= bus.ctrl_pkt_len;
        r_addr   <= '0;
      end else if (w_rd_en) begin
        r_addr <= r_addr + LEN_W'(1);
      end
      r_pv <= (r_pv << 1) | RD_LAT'(w_rd_en);
      r_ps <= (r_ps << 1) | RD_LAT'(w_rd_en && w_smp_sop);
      r_pe <= (r_pe << 1) | RD_LAT'(w_rd_en && w_last_addr);
    end
  end

  // The header is only pushed at grant, when the pipe is empty, so the two writers never collide.
  assign w_push    = r_pv[RD_LAT-1] || w_hdr_push;
  assign w_wr_word = w_hdr_push ? w_hdr_word
                                : {bus.rd_data, r_ps[RD_LAT-1], r_pe[RD_LAT-1]};

  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_D-1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_D-1)) ? '0 : r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_dsp) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_comb begin
    bus.req_ack = '0;
    if (r_state == S_ACK) bus.req_ack[r_grant] = 1'b1;
  end

  // Head fields are masked when empty so stale RAM words never leak onto the bus.
  assign bus.rd_en                     = w_rd_en;
  assign bus.rd_sel                    = r_grant;
  assign bus.rd_addr                   = r_addr;
  assign bus.avst_source_valid         = !w_empty;
  assign bus.avst_source_data          = w_empty ? '0 : w_head[WRD_W-1:2];
  assign bus.avst_source_startofpacket = !w_empty && w_head[1];
  assign bus.avst_source_endofpacket   = !w_empty && w_head[0];
  assign bus.avst_source_channel       = w_empty ? 16'h0 : 16'(r_grant);
  assign o_dbg_state                   = r_state;
  assign o_dbg_fifo_cnt                = r_cnt;
endmodule
